regfile_wb: RTL and testbench
=============================

Name: regfile_wb

Overview:
Writeback-side endpoint for the execute stage's (rd_addr, rd_data, wen) result bus. It contains:
- the 32x32 integer register file (x0 hardwired to zero)
- two bypassed read ports serving decode
- a per-register outstanding-write scoreboard that decode uses for stall decisions
- a single-cycle debug access port sharing the array's write port

It sits between ex (writer) and id (reader) and closes the loop of the pipeline.

Parameters:
REG_NUM, 32, number of architectural registers (x0..x31).
SB_CNT_W, 2, width of each scoreboard counter; max outstanding writes per register is 2^SB_CNT_W-1.

Ports:
clk  input  1  core clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-high
issue_valid_i  input  1  id issues an instruction that will write rd
issue_rd_i  input  5  destination of issuing instruction
issue_ready_o  output  1  scoreboard can accept the reservation
wb_wen_i  input  1  write request from ex (rd_wen_o of ex)
wb_rd_addr_i  input  5  write address from ex
wb_rd_data_i  input  32  write data from ex
rs1_addr_i  input  5  read port 1 address
rs1_data_o  output  32  read port 1 data, combinational
rs1_busy_o  output  1  rs1 has an outstanding write not yet visible
rs2_addr_i  input  5  read port 2 address
rs2_data_o  output  32  read port 2 data, combinational
rs2_busy_o  output  1  rs2 has an outstanding write not yet visible
flush_i  input  1  pipeline flush; clears all reservations
dbg_req_i  input  1  debug access request, held until dbg_ack_o
dbg_we_i  input  1  1 = write, 0 = read
dbg_addr_i  input  5  debug register address
dbg_wdata_i  input  32  debug write data
dbg_ack_o  output  1  one-cycle completion pulse
dbg_rdata_o  output  32  debug read data, valid while dbg_ack_o=1

Behaviour:

Write path:
- A write fires in cycle N when wb_wen_i=1 and wb_rd_addr_i!=0.
- On the cycle-N edge the write is captured into a pending register (pend_v, pend_addr, pend_data).
- The pending write commits to the array on the cycle-N+1 edge.
- The pipeline write is never back-pressured.
- Writes to x0 are dropped entirely.

Read path (per port):
- x0 reads 0.
- Priority, highest first: firing wb input (same-cycle, write-first) > pending register > array.

Scoreboard:
- Per-register counter cnt[r].
- Issue fire = issue_valid_i & issue_ready_o & issue_rd_i!=0; it increments cnt.
- A wb fire decrements cnt[wb_rd_addr_i].
- If both hit the same register, cnt is unchanged.
- Decrement at 0 saturates at 0.
- issue_ready_o = 0 when cnt[issue_rd_i] is at max, else 1. x0 is always ready.
- rsN_busy_o = (cnt[rsN]!=0) & ~(wb fire to rsN with cnt[rsN]==1), so data bypassed in cycle N clears busy in cycle N.
- flush_i: all cnt cleared to 0 on that edge; a simultaneous issue is ignored. A pending or firing wb still writes data, with no count change.

Debug FSM, states IDLE, ACK:
- IDLE -> ACK when dbg_req_i=1 and (dbg_we_i=0 or pend_v=0).
- A debug write waits in IDLE while a pending commit occupies the write port; pipeline always has priority.
- On the IDLE->ACK edge:
  - a write updates the array (x0 ignored);
  - a read captures dbg_rdata_o via the port-read bypass priority.
- ACK: dbg_ack_o=1 for exactly one cycle, then return to IDLE.
- Back-to-back requests give at most one ack every 2 cycles.
- Debug writes do not touch the scoreboard.
- If a debug write and a wb fire target the same register in the same cycle, the debug write lands first and the wb write commits one edge later (wb wins).

Reset (synchronous, rst=1 at an edge):
- array cleared to 0
- all cnt=0
- pend_v=0
- FSM=IDLE, dbg_ack_o=0, dbg_rdata_o=0
- rst overrides all same-cycle events.
- Reset asserted mid-debug-transaction aborts it with no ack.

Decomposition:
- Shared defines file gains the register-file constants: `RegNum (32), `RegAddrBus (4:0), `RegBus (31:0).
- Existing constants are reused: `ZeroWord, `ZeroReg, `WriteEnable, `WriteDisable.
- Debug FSM state encodings are local parameters.
- One natural sub-module: rf_scoreboard, holding the counters, issue_ready and busy logic.

Test Plan:
1. Reset, then read all 32 registers via rs1/rs2 and debug -> all 0; dbg_ack_o pulses once per request.
2. wb x5=0x1234_5678 in cycle N with rs1_addr=5 -> rs1_data_o=0x12345678 in N (bypass), N+1 (pending) and N+2 (array); wb to x0 with 0xFFFF_FFFF -> x0 still reads 0.
3. Issue rd=7 three times (cnt 3) -> issue_ready_o=0 for rd=7 and 1 for rd=8; rs1_busy_o=1 until the third wb to x7; same-cycle issue+wb on x7 leaves cnt unchanged.
4. flush_i with cnt[3]=2 and wb x3=0xA5 firing -> all busy 0 next cycle, x3 reads 0xA5, later stray wb decrements leave cnt at 0.
5. Debug write x9=0xDEAD_BEEF while pend_v=1 -> ack delayed one cycle; debug read x9 -> dbg_rdata_o=0xDEADBEEF with ack; debug write to x0 acks, x0 reads 0.
6. rst asserted during debug ACK and with pend_v=1 -> next cycle dbg_ack_o=0, pending write lost, all registers 0.

Source files
------------

// File: rtl/regfile_wb_pkg.sv
// Shared register-file constants and helpers for the writeback endpoint.
package regfile_wb_pkg;
  localparam int REG_NUM_C  = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  localparam logic [REG_DATA_W-1:0] ZERO_WORD     = '0;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG      = '0;
  localparam logic                  WRITE_ENABLE  = 1'b1;
  localparam logic                  WRITE_DISABLE = 1'b0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  function automatic logic wr_fire(input logic wen, input reg_addr_t addr);
    return (wen == WRITE_ENABLE) && (addr != ZERO_REG);
  endfunction
endpackage

// File: rtl/regfile_wb_scoreboard.sv
// Per-register outstanding-write counters driving issue back-pressure and read-port busy flags.
module rf_scoreboard
  import regfile_wb_pkg::*;
#(
  parameter int REG_NUM  = REG_NUM_C,
  parameter int SB_CNT_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  output logic                  issue_ready,
  input  logic                  flush,
  input  logic                  wb_fire,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic                  rs1_busy,
  output logic                  rs2_busy
);
  localparam logic [SB_CNT_W-1:0] CNT_MAX = '1;
  localparam logic [SB_CNT_W-1:0] CNT_ONE = SB_CNT_W'(1);

  logic [SB_CNT_W-1:0] cnt     [REG_NUM];
  logic [SB_CNT_W-1:0] cnt_nxt [REG_NUM];
  logic                issue_fire;

  assign issue_ready = (issue_rd == ZERO_REG) || (cnt[issue_rd] != CNT_MAX);
  assign issue_fire  = issue_valid && issue_ready && (issue_rd != ZERO_REG) && !flush;

  // A retiring write whose count is about to hit zero is already visible through the bypass.
  assign rs1_busy = (cnt[rs1_addr] != '0) &&
                    !(wb_fire && (wb_addr == rs1_addr) && (cnt[rs1_addr] == CNT_ONE));
  assign rs2_busy = (cnt[rs2_addr] != '0) &&
                    !(wb_fire && (wb_addr == rs2_addr) && (cnt[rs2_addr] == CNT_ONE));

  always_comb begin
    for (int r = 0; r < REG_NUM; r++) begin
      cnt_nxt[r] = cnt[r];
      if (flush) begin
        cnt_nxt[r] = '0;
      end else if (issue_fire && (issue_rd == REG_ADDR_W'(r)) &&
                   !(wb_fire && (wb_addr == REG_ADDR_W'(r)))) begin
        cnt_nxt[r] = cnt[r] + 1'b1;
      end else if (wb_fire && (wb_addr == REG_ADDR_W'(r)) &&
                   !(issue_fire && (issue_rd == REG_ADDR_W'(r))) && (cnt[r] != '0)) begin
        cnt_nxt[r] = cnt[r] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < REG_NUM; r++) cnt[r] <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end
endmodule

// File: rtl/regfile_wb.sv
// Writeback endpoint: 32x32 register file with pending-write stage, bypassed read ports,
// write scoreboard and a single-cycle debug access port sharing the array write port.
module regfile_wb
  import regfile_wb_pkg::*;
#(
  parameter int REG_NUM  = REG_NUM_C,
  parameter int SB_CNT_W = 2,
  parameter int DATA_W   = REG_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid_i,
  input  logic [REG_ADDR_W-1:0] issue_rd_i,
  output logic                  issue_ready_o,
  input  logic                  wb_wen_i,
  input  logic [REG_ADDR_W-1:0] wb_rd_addr_i,
  input  logic [DATA_W-1:0]     wb_rd_data_i,
  input  logic [REG_ADDR_W-1:0] rs1_addr_i,
  output logic [DATA_W-1:0]     rs1_data_o,
  output logic                  rs1_busy_o,
  input  logic [REG_ADDR_W-1:0] rs2_addr_i,
  output logic [DATA_W-1:0]     rs2_data_o,
  output logic                  rs2_busy_o,
  input  logic                  flush_i,
  input  logic                  dbg_req_i,
  input  logic                  dbg_we_i,
  input  logic [REG_ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0]     dbg_wdata_i,
  output logic                  dbg_ack_o,
  output logic [DATA_W-1:0]     dbg_rdata_o
);
  localparam logic DBG_IDLE = 1'b0;
  localparam logic DBG_ACK  = 1'b1;

  logic [DATA_W-1:0]     regs [REG_NUM];
  logic                  wb_fire;
  logic                  pend_v_p1;
  logic [REG_ADDR_W-1:0] pend_addr_p1;
  logic [DATA_W-1:0]     pend_data_p1;
  logic                  dbg_state;
  logic                  dbg_go;
  logic                  dbg_wr;
  logic [DATA_W-1:0]     dbg_rd_val;

  function automatic logic [DATA_W-1:0] port_read(
    input logic [REG_ADDR_W-1:0] addr,
    input logic                  fire,
    input logic [REG_ADDR_W-1:0] fire_addr,
    input logic [DATA_W-1:0]     fire_data,
    input logic                  pv,
    input logic [REG_ADDR_W-1:0] paddr,
    input logic [DATA_W-1:0]     pdata,
    input logic [DATA_W-1:0]     arr
  );
    if (addr == ZERO_REG)                return '0;
    else if (fire && (fire_addr == addr)) return fire_data;
    else if (pv && (paddr == addr))       return pdata;
    else                                  return arr;
  endfunction

  assign wb_fire = wr_fire(wb_wen_i, wb_rd_addr_i);

  always_comb begin
    rs1_data_o = port_read(rs1_addr_i, wb_fire, wb_rd_addr_i, wb_rd_data_i,
                           pend_v_p1, pend_addr_p1, pend_data_p1, regs[rs1_addr_i]);
    rs2_data_o = port_read(rs2_addr_i, wb_fire, wb_rd_addr_i, wb_rd_data_i,
                           pend_v_p1, pend_addr_p1, pend_data_p1, regs[rs2_addr_i]);
    dbg_rd_val = port_read(dbg_addr_i, wb_fire, wb_rd_addr_i, wb_rd_data_i,
                           pend_v_p1, pend_addr_p1, pend_data_p1, regs[dbg_addr_i]);
  end

  // ---- stage p1: pending write, commits to the array one edge after capture ----
  always_ff @(posedge clk) begin
    if (rst) pend_v_p1 <= 1'b0;
    else     pend_v_p1 <= wb_fire;
  end

  always_ff @(posedge clk) begin
    pend_addr_p1 <= wb_rd_addr_i;
    pend_data_p1 <= wb_rd_data_i;
  end

  // Debug writes only proceed when no pending commit owns the write port.
  assign dbg_go = (dbg_state == DBG_IDLE) && dbg_req_i &&
                  ((dbg_we_i == WRITE_DISABLE) || !pend_v_p1);
  assign dbg_wr = dbg_go && (dbg_we_i == WRITE_ENABLE) && (dbg_addr_i != ZERO_REG);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) regs[i] <= ZERO_WORD;
    end else begin
      if (dbg_wr)    regs[dbg_addr_i]   <= dbg_wdata_i;
      if (pend_v_p1) regs[pend_addr_p1] <= pend_data_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dbg_state   <= DBG_IDLE;
      dbg_rdata_o <= ZERO_WORD;
    end else begin
      case (dbg_state)
        DBG_IDLE: begin
          if (dbg_go) begin
            dbg_state <= DBG_ACK;
            if (dbg_we_i == WRITE_DISABLE) dbg_rdata_o <= dbg_rd_val;
          end
        end
        default: dbg_state <= DBG_IDLE;
      endcase
    end
  end

  assign dbg_ack_o = (dbg_state == DBG_ACK);

  rf_scoreboard #(
    .REG_NUM (REG_NUM),
    .SB_CNT_W(SB_CNT_W)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .issue_valid(issue_valid_i),
    .issue_rd   (issue_rd_i),
    .issue_ready(issue_ready_o),
    .flush      (flush_i),
    .wb_fire    (wb_fire),
    .wb_addr    (wb_rd_addr_i),
    .rs1_addr   (rs1_addr_i),
    .rs2_addr   (rs2_addr_i),
    .rs1_busy   (rs1_busy_o),
    .rs2_busy   (rs2_busy_o)
  );
endmodule

// File: tb/tb_regfile_wb.sv
// Directed bench for regfile_wb: bypass/pending/array reads, scoreboard, flush, debug port, reset.
module tb_regfile_wb;
  logic        clk;
  logic        rst;
  logic        issue_valid_i;
  logic [4:0]  issue_rd_i;
  logic        issue_ready_o;
  logic        wb_wen_i;
  logic [4:0]  wb_rd_addr_i;
  logic [31:0] wb_rd_data_i;
  logic [4:0]  rs1_addr_i;
  logic [31:0] rs1_data_o;
  logic        rs1_busy_o;
  logic [4:0]  rs2_addr_i;
  logic [31:0] rs2_data_o;
  logic        rs2_busy_o;
  logic        flush_i;
  logic        dbg_req_i;
  logic        dbg_we_i;
  logic [4:0]  dbg_addr_i;
  logic [31:0] dbg_wdata_i;
  logic        dbg_ack_o;
  logic [31:0] dbg_rdata_o;

  int passed = 0;
  int total  = 0;

  regfile_wb dut (
    .clk          (clk),
    .rst          (rst),
    .issue_valid_i(issue_valid_i),
    .issue_rd_i   (issue_rd_i),
    .issue_ready_o(issue_ready_o),
    .wb_wen_i     (wb_wen_i),
    .wb_rd_addr_i (wb_rd_addr_i),
    .wb_rd_data_i (wb_rd_data_i),
    .rs1_addr_i   (rs1_addr_i),
    .rs1_data_o   (rs1_data_o),
    .rs1_busy_o   (rs1_busy_o),
    .rs2_addr_i   (rs2_addr_i),
    .rs2_data_o   (rs2_data_o),
    .rs2_busy_o   (rs2_busy_o),
    .flush_i      (flush_i),
    .dbg_req_i    (dbg_req_i),
    .dbg_we_i     (dbg_we_i),
    .dbg_addr_i   (dbg_addr_i),
    .dbg_wdata_i  (dbg_wdata_i),
    .dbg_ack_o    (dbg_ack_o),
    .dbg_rdata_o  (dbg_rdata_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Wb requests driven before the call last one cycle; the request is dropped after the ack.
  task automatic dbg_op(input string tag, input logic we, input logic [4:0] addr,
                        input logic [31:0] wdata, input int exp_lat, input logic [31:0] exp_rdata);
    int n;
    n = 0;
    dbg_req_i = 1'b1; dbg_we_i = we; dbg_addr_i = addr; dbg_wdata_i = wdata;
    do begin
      tick();
      wb_wen_i = 1'b0;
      n++;
    end while (!dbg_ack_o && n < 8);
    chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
    if (!we) chk({tag, "_rdata"}, dbg_rdata_o, exp_rdata);
    dbg_req_i = 1'b0;
    tick();
    chk({tag, "_ack_drop"}, 32'(dbg_ack_o), 32'd0);
  endtask

  initial begin
    rst = 1'b1; issue_valid_i = 1'b0; issue_rd_i = '0; wb_wen_i = 1'b0; wb_rd_addr_i = '0;
    wb_rd_data_i = '0; rs1_addr_i = '0; rs2_addr_i = '0; flush_i = 1'b0; dbg_req_i = 1'b0;
    dbg_we_i = 1'b0; dbg_addr_i = '0; dbg_wdata_i = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_ack", 32'(dbg_ack_o), 32'd0);
    chk("rst_rdata", dbg_rdata_o, 32'd0);
    chk("rst_ready", 32'(issue_ready_o), 32'd1);

    // 1: everything reads zero after reset
    for (int i = 0; i < 32; i++) begin
      rs1_addr_i = 5'(i); rs2_addr_i = 5'(31 - i);
      #1;
      chk("rst_rs1", rs1_data_o, 32'd0);
      chk("rst_rs2", rs2_data_o, 32'd0);
      chk("rst_busy", 32'({rs1_busy_o, rs2_busy_o}), 32'd0);
    end
    for (int i = 0; i < 32; i += 4) dbg_op("rst_dbg_rd", 1'b0, 5'(i), 32'd0, 1, 32'd0);
    dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 5'd1;
    tick(); chk("b2b_ack0", 32'(dbg_ack_o), 32'd1);
    tick(); chk("b2b_ack1", 32'(dbg_ack_o), 32'd0);
    tick(); chk("b2b_ack2", 32'(dbg_ack_o), 32'd1);
    dbg_req_i = 1'b0;
    tick(); chk("b2b_ack3", 32'(dbg_ack_o), 32'd0);

    // 2: bypass, pending, array; x0 writes dropped
    wb_wen_i = 1'b1; wb_rd_addr_i = 5'd5; wb_rd_data_i = 32'h1234_5678; rs1_addr_i = 5'd5;
    #1; chk("x5_bypass", rs1_data_o, 32'h1234_5678);
    tick(); wb_wen_i = 1'b0;
    #1; chk("x5_pending", rs1_data_o, 32'h1234_5678);
    tick(); chk("x5_array", rs1_data_o, 32'h1234_5678);
    wb_wen_i = 1'b1; wb_rd_addr_i = 5'd0; wb_rd_data_i = 32'hFFFF_FFFF; rs1_addr_i = 5'd0;
    #1; chk("x0_bypass", rs1_data_o, 32'd0);
    tick(); wb_wen_i = 1'b0;
    #1; chk("x0_pending", rs1_data_o, 32'd0);
    tick(); chk("x0_array", rs1_data_o, 32'd0);

    // 3: scoreboard fill, full back-pressure, same-cycle issue+wb, drain
    issue_valid_i = 1'b1; issue_rd_i = 5'd7; rs1_addr_i = 5'd7;
    #1; chk("sb_ready_c0", 32'(issue_ready_o), 32'd1);
    tick(); chk("sb_busy_c1", 32'(rs1_busy_o), 32'd1);
    tick(); chk("sb_ready_c2", 32'(issue_ready_o), 32'd1);
    tick(); chk("sb_full_x7", 32'(issue_ready_o), 32'd0);
    issue_rd_i = 5'd8;
    #1; chk("sb_ready_x8", 32'(issue_ready_o), 32'd1);
    issue_valid_i = 1'b0; issue_rd_i = 5'd7;
    wb_wen_i = 1'b1; wb_rd_addr_i = 5'd7; wb_rd_data_i = 32'h11;
    #1; chk("sb_busy_c3", 32'(rs1_busy_o), 32'd1);
    tick(); wb_wen_i = 1'b0;
    #1; chk("sb_busy_c2", 32'(rs1_busy_o), 32'd1);
    issue_valid_i = 1'b1; wb_wen_i = 1'b1; wb_rd_data_i = 32'h22;
    #1; chk("sb_same_ready", 32'(issue_ready_o), 32'd1);
    tick(); wb_wen_i = 1'b0;
    #1; chk("sb_same_ready2", 32'(issue_ready_o), 32'd1);
    tick(); chk("sb_same_unchanged", 32'(issue_ready_o), 32'd0);
    issue_valid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wb_wen_i = 1'b1; wb_rd_data_i = 32'h100 + 32'(k);
      #1;
      chk("sb_drain_busy", 32'(rs1_busy_o), (k < 2) ? 32'd1 : 32'd0);
      chk("sb_drain_data", rs1_data_o, 32'h100 + 32'(k));
      tick(); wb_wen_i = 1'b0;
    end
    #1; chk("sb_drained", 32'(rs1_busy_o), 32'd0);

    // 4: flush with a firing wb and a simultaneous issue
    issue_valid_i = 1'b1; issue_rd_i = 5'd3; rs2_addr_i = 5'd3;
    tick(); tick();
    flush_i = 1'b1; wb_wen_i = 1'b1; wb_rd_addr_i = 5'd3; wb_rd_data_i = 32'hA5;
    #1; chk("fl_busy_pre", 32'(rs2_busy_o), 32'd1);
    tick(); flush_i = 1'b0; wb_wen_i = 1'b0; issue_valid_i = 1'b0;
    #1;
    chk("fl_busy_rs2", 32'(rs2_busy_o), 32'd0);
    chk("fl_busy_rs1", 32'(rs1_busy_o), 32'd0);
    chk("fl_x3_pending", rs2_data_o, 32'hA5);
    tick(); chk("fl_x3_array", rs2_data_o, 32'hA5);
    wb_wen_i = 1'b1; wb_rd_data_i = 32'h5A;
    tick(); wb_wen_i = 1'b0;
    #1; chk("fl_stray_busy", 32'(rs2_busy_o), 32'd0);
    issue_valid_i = 1'b1;
    #1; chk("fl_sat_ready0", 32'(issue_ready_o), 32'd1);
    tick(); tick(); chk("fl_sat_ready2", 32'(issue_ready_o), 32'd1);
    tick(); chk("fl_sat_full", 32'(issue_ready_o), 32'd0);
    issue_valid_i = 1'b0; flush_i = 1'b1;
    tick(); flush_i = 1'b0;

    // 5: debug port against the pipeline write port
    wb_wen_i = 1'b1; wb_rd_addr_i = 5'd4; wb_rd_data_i = 32'h44;
    tick(); wb_wen_i = 1'b0;
    dbg_op("dbg_wr_x9", 1'b1, 5'd9, 32'hDEAD_BEEF, 2, 32'd0);
    dbg_op("dbg_rd_x9", 1'b0, 5'd9, 32'd0, 1, 32'hDEAD_BEEF);
    rs1_addr_i = 5'd4; rs2_addr_i = 5'd9;
    #1;
    chk("dbg_x4", rs1_data_o, 32'h44);
    chk("dbg_x9_port", rs2_data_o, 32'hDEAD_BEEF);
    dbg_op("dbg_wr_x0", 1'b1, 5'd0, 32'hFFFF_FFFF, 1, 32'd0);
    rs1_addr_i = 5'd0;
    #1; chk("dbg_x0_port", rs1_data_o, 32'd0);
    dbg_op("dbg_rd_x0", 1'b0, 5'd0, 32'd0, 1, 32'd0);
    wb_wen_i = 1'b1; wb_rd_addr_i = 5'd10; wb_rd_data_i = 32'hCAFE_0000;
    dbg_op("dbg_rd_byp", 1'b0, 5'd10, 32'd0, 1, 32'hCAFE_0000);
    wb_wen_i = 1'b1; wb_rd_addr_i = 5'd11; wb_rd_data_i = 32'h1111;
    dbg_op("dbg_wr_x11", 1'b1, 5'd11, 32'h2222, 1, 32'd0);
    rs1_addr_i = 5'd11;
    #1; chk("dbg_wb_wins", rs1_data_o, 32'h1111);

    // 6: reset during ACK with a pending write and an outstanding reservation
    wb_wen_i = 1'b1; wb_rd_addr_i = 5'd12; wb_rd_data_i = 32'h77;
    dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 5'd5;
    issue_valid_i = 1'b1; issue_rd_i = 5'd13;
    tick();
    wb_wen_i = 1'b0; dbg_req_i = 1'b0; issue_valid_i = 1'b0; rs1_addr_i = 5'd13;
    #1;
    chk("rst6_ack_pre", 32'(dbg_ack_o), 32'd1);
    chk("rst6_busy_pre", 32'(rs1_busy_o), 32'd1);
    rst = 1'b1;
    tick(); rst = 1'b0;
    #1;
    chk("rst6_ack", 32'(dbg_ack_o), 32'd0);
    chk("rst6_rdata", dbg_rdata_o, 32'd0);
    chk("rst6_busy", 32'(rs1_busy_o), 32'd0);
    rs1_addr_i = 5'd12; rs2_addr_i = 5'd5;
    #1;
    chk("rst6_pend_lost", rs1_data_o, 32'd0);
    chk("rst6_x5", rs2_data_o, 32'd0);
    tick(); chk("rst6_pend_late", rs1_data_o, 32'd0);
    for (int i = 0; i < 32; i++) begin
      rs1_addr_i = 5'(i);
      #1; chk("rst6_all", rs1_data_o, 32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
